// File: rtl/score_bcd_ctrl.sv
// score_bcd_ctrl: four-digit BCD score accumulator fed by a valid/ready
// points port, adding one digit per cycle with ripple carry.
//
// Parameters:
//   PTS_MAX   largest point value taken per request (1..9); larger
//             requests are clamped to it
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clear     synchronous clear of score and overflow, aborts an add
//   add_valid points request valid
//   add_ready request taken when add_valid && add_ready at an edge
//   add_pts   binary points to add
//   score_1..score_4  BCD ones, tens, hundreds, thousands (registered)
//   busy      a digit walk is in progress
//   overflow  sticky, a carry left the thousands digit
//
// Build option: define SCORE_SATURATE_EN to pin the score at 9999 on
// overflow; otherwise the score wraps modulo 10000.

module score_bcd_ctrl #(
   parameter int PTS_MAX = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       add_valid,
   output logic       add_ready,
   input  logic [3:0] add_pts,
   output logic [3:0] score_1,
   output logic [3:0] score_2,
   output logic [3:0] score_3,
   output logic [3:0] score_4,
   output logic       busy,
   output logic       overflow
);

   localparam logic [3:0] PtsCap = 4'(PTS_MAX);

   typedef enum logic {
      S_IDLE,
      S_ADD
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] dig_q [4];
   logic [3:0] dig_d [4];
   logic [3:0] carry_q, carry_d;
   logic [1:0] idx_q, idx_d;
   logic       ovf_q, ovf_d;
   logic       init_q, init_d;

   logic [4:0] sum;
   logic       sum_wrap;
   logic [3:0] sum_dig;
   logic       last_dig;
   logic [3:0] pts_cap;

   // Digit adder for the digit currently addressed by idx_q.
   // sum is at most 9 + 9 = 18, so subtracting 10 in 4 bits is exact.
   always_comb begin
      sum      = {1'b0, dig_q[idx_q]} + {1'b0, carry_q};
      sum_wrap = (sum > 5'd9);
      sum_dig  = sum_wrap ? (sum[3:0] - 4'd10) : sum[3:0];
      last_dig = (idx_q == 2'd3);
   end

   always_comb begin
      pts_cap = (add_pts > PtsCap) ? PtsCap : add_pts;
   end

   // add_ready stays low until one edge has passed after reset release,
   // so nothing is accepted while rst_n is low or on the release edge.
   assign add_ready = init_q && (state_q == S_IDLE) && !clear;
   assign busy      = (state_q == S_ADD);
   assign overflow  = ovf_q;
   assign score_1   = dig_q[0];
   assign score_2   = dig_q[1];
   assign score_3   = dig_q[2];
   assign score_4   = dig_q[3];

   always_comb begin
      state_d = state_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      ovf_d   = ovf_q;
      init_d  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dig_d[i] = dig_q[i];
      end

      if (clear) begin
         state_d = S_IDLE;
         carry_d = '0;
         idx_d   = '0;
         ovf_d   = 1'b0;
         for (int i = 0; i < 4; i++) begin
            dig_d[i] = '0;
         end
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (add_valid && add_ready) begin
                  carry_d = pts_cap;
                  idx_d   = '0;
                  state_d = S_ADD;
               end
            end
            S_ADD: begin
`ifdef SCORE_SATURATE_EN
               // Once saturated the digits are frozen at 9999; the walk
               // still runs so handshake timing does not depend on it.
               if (!ovf_q) begin
                  dig_d[idx_q] = sum_dig;
               end
               if (last_dig && sum_wrap) begin
                  ovf_d = 1'b1;
                  for (int i = 0; i < 4; i++) begin
                     dig_d[i] = 4'd9;
                  end
               end
`else
               dig_d[idx_q] = sum_dig;
               if (last_dig && sum_wrap) begin
                  ovf_d = 1'b1;
               end
`endif
               if (!sum_wrap || last_dig) begin
                  state_d = S_IDLE;
                  carry_d = '0;
                  idx_d   = '0;
               end else begin
                  carry_d = 4'd1;
                  idx_d   = idx_q + 2'd1;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         carry_q <= '0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
         init_q  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            dig_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         ovf_q   <= ovf_d;
         init_q  <= init_d;
         for (int i = 0; i < 4; i++) begin
            dig_q[i] <= dig_d[i];
         end
      end
   end

endmodule

// File: tb/tb_score_bcd_ctrl.sv
// Directed bench for score_bcd_ctrl: handshake timing, carry walk,
// clamping, clear priority, overflow and asynchronous reset.

module tb_score_bcd_ctrl;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       add_valid;
   logic       add_ready;
   logic [3:0] add_pts;
   logic [3:0] score_1, score_2, score_3, score_4;
   logic       busy;
   logic       overflow;

   int n_cmp = 0;
   int n_err = 0;
   int k;

   score_bcd_ctrl #(.PTS_MAX(9)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .add_valid (add_valid),
      .add_ready (add_ready),
      .add_pts   (add_pts),
      .score_1   (score_1),
      .score_2   (score_2),
      .score_3   (score_3),
      .score_4   (score_4),
      .busy      (busy),
      .overflow  (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] score();
      return {score_4, score_3, score_2, score_1};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one request and returns the number of edges after the
   // accepting edge until add_ready returns (bounded).
   task automatic do_add(input logic [3:0] pts, output int cyc);
      int w;
      w = 0;
      while (!add_ready && w < 8) begin
         step();
         w++;
      end
      add_valid = 1'b1;
      add_pts   = pts;
      step();
      add_valid = 1'b0;
      add_pts   = 4'd0;
      cyc = 0;
      while (!add_ready && cyc < 8) begin
         step();
         cyc++;
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic build(input int nines, input logic [3:0] extra);
      int c;
      do_clear();
      for (int i = 0; i < nines; i++) begin
         do_add(4'd9, c);
      end
      if (extra != 4'd0) begin
         do_add(extra, c);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      add_valid = 1'b0;
      add_pts   = 4'd0;

      // Reset state
      #3;
      check("rst_score", score(), 16'h0000);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_ovf", 16'(overflow), 16'd0);
      check("rst_ready", 16'(add_ready), 16'd0);
      step();
      check("rst_ready_edge", 16'(add_ready), 16'd0);
      rst_n = 1'b1;
      #1;
      check("rel_ready", 16'(add_ready), 16'd0);
      step();
      check("rel_ready_edge", 16'(add_ready), 16'd1);

      // 7 then 5 -> 0012
      do_add(4'd7, k);
      check("add7_cyc", 16'(k), 16'd1);
      check("add7_score", score(), 16'h0007);
      do_add(4'd5, k);
      check("add5_cyc", 16'(k), 16'd2);
      check("add5_score", score(), 16'h0012);
      check("add5_ovf", 16'(overflow), 16'd0);

      // clamping and zero add
      clear = 1'b1;
      #1;
      check("clr_ready", 16'(add_ready), 16'd0);
      step();
      clear = 1'b0;
      check("clr_score", score(), 16'h0000);
      do_add(4'd15, k);
      check("clamp_cyc", 16'(k), 16'd1);
      check("clamp_score", score(), 16'h0009);
      do_add(4'd0, k);
      check("zero_cyc", 16'(k), 16'd1);
      check("zero_score", score(), 16'h0009);

      // 0999 + 1, edge by edge
      build(111, 4'd0);
      check("b999", score(), 16'h0999);
      add_valid = 1'b1;
      add_pts   = 4'd1;
      step();
      add_valid = 1'b0;
      check("c_N_ready", 16'(add_ready), 16'd0);
      check("c_N_busy", 16'(busy), 16'd1);
      step();
      check("c_N1_score", score(), 16'h0990);
      check("c_N1_ready", 16'(add_ready), 16'd0);
      step();
      check("c_N2_score", score(), 16'h0900);
      step();
      check("c_N3_score", score(), 16'h0000);
      check("c_N3_ready", 16'(add_ready), 16'd0);
      step();
      check("c_N4_score", score(), 16'h1000);
      check("c_N4_ready", 16'(add_ready), 16'd1);
      check("c_N4_busy", 16'(busy), 16'd0);

      // clear aborting 0999 + 1 at N+2
      build(111, 4'd0);
      add_valid = 1'b1;
      add_pts   = 4'd1;
      step();
      add_valid = 1'b0;
      step();
      check("ab_N1_score", score(), 16'h0990);
      clear = 1'b1;
      step();
      check("ab_score", score(), 16'h0000);
      check("ab_ovf", 16'(overflow), 16'd0);
      check("ab_busy", 16'(busy), 16'd0);
      clear = 1'b0;
      #1;
      check("ab_ready", 16'(add_ready), 16'd1);

      // clear wins over a same-cycle request
      add_valid = 1'b1;
      add_pts   = 4'd5;
      clear     = 1'b1;
      step();
      check("cv_busy", 16'(busy), 16'd0);
      check("cv_score", score(), 16'h0000);
      add_valid = 1'b0;
      clear     = 1'b0;
      step();
      check("cv_busy2", 16'(busy), 16'd0);
      check("cv_score2", score(), 16'h0000);

      // 9998 + 3 overflow
      build(1110, 4'd8);
      check("b9998", score(), 16'h9998);
      check("b9998_ovf", 16'(overflow), 16'd0);
      do_add(4'd3, k);
      check("ovf_cyc", 16'(k), 16'd4);
`ifdef SCORE_SATURATE_EN
      check("ovf_score", score(), 16'h9999);
`else
      check("ovf_score", score(), 16'h0001);
`endif
      check("ovf_flag", 16'(overflow), 16'd1);
      do_add(4'd0, k);
      check("ovf_sticky", 16'(overflow), 16'd1);
`ifdef SCORE_SATURATE_EN
      do_add(4'd4, k);
      check("sat_hold", score(), 16'h9999);
`else
      check("wrap_hold", score(), 16'h0001);
`endif
      do_clear();
      check("ovf_clr", 16'(overflow), 16'd0);
      check("ovf_clr_score", score(), 16'h0000);

      // asynchronous reset in the middle of 0018 + 5
      build(2, 4'd0);
      check("b18", score(), 16'h0018);
      add_valid = 1'b1;
      add_pts   = 4'd5;
      step();
      add_valid = 1'b0;
      step();
      check("ar_N1_score", score(), 16'h0013);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_score", score(), 16'h0000);
      check("ar_busy", 16'(busy), 16'd0);
      check("ar_ready", 16'(add_ready), 16'd0);
      #2;
      rst_n = 1'b1;
      step();
      check("ar_post_score", score(), 16'h0000);
      check("ar_post_busy", 16'(busy), 16'd0);
      check("ar_post_ready", 16'(add_ready), 16'd1);
      step();
      check("ar_idle_score", score(), 16'h0000);
      do_add(4'd4, k);
      check("ar_new_score", score(), 16'h0004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/score_bcd_ctrl.md
SCORE_BCD_CTRL -- requirements
Module: score_bcd_ctrl

Interface
- REQ-001 Parameter: PTS_MAX, default 9, largest point value accepted per request; range 1..9.
- REQ-002 Port: clk  in  1  system clock; all state on rising edge.
- REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
- REQ-004 Port: clear  in  1  synchronous score clear, active-high.
- REQ-005 Port: add_valid  in  1  points request valid.
- REQ-006 Port: add_ready  out  1  request accepted when add_valid && add_ready at a rising edge.
- REQ-007 Port: add_pts  in  4  points to add, binary.
- REQ-008 Port: score_1, score_2, score_3, score_4  out  4 each  BCD digits: ones, tens, hundreds, thousands; feed the 4-digit segment display.
- REQ-009 Port: busy  out  1  addition in progress.
- REQ-010 Port: overflow  out  1  sticky; a carry left the thousands digit.

Function
- REQ-011 States: IDLE, ADD. add_ready = (state==IDLE) && !clear; busy = (state==ADD).
- REQ-012 IDLE: on accept, latch carry = min(add_pts, PTS_MAX), digit index idx=0, go to ADD.
- REQ-013 ADD: per cycle, sum = digit[idx] + carry; if sum>9 then digit[idx]=sum-10, carry=1, else digit[idx]=sum, carry=0.
- REQ-014 ADD exit: return to IDLE in the same edge where carry becomes 0 or idx==3; otherwise idx increments.
- REQ-015 Latency: request accepted at edge N updates ones digit at N+1; a carry through k digits completes at edge N+k (k=1..4); add_ready high again from edge N+k.
- REQ-016 add_pts=0: accepted, one ADD cycle, digits unchanged.
- REQ-017 Carry out of thousands digit (idx==3, sum>9): overflow set to 1 and stays 1 until clear or reset; digit handling per REQ-024/025.
- REQ-018 Digits change only in ADD state, on clear or on reset; outputs are registered and never hold a value above 9.
- REQ-019 clear: at the next edge all digits=0, overflow=0, state=IDLE, carry=0; overrides an in-progress ADD (aborts it) and any same-cycle add_valid (not accepted).
- REQ-020 add_valid while busy: not accepted and not lost; the requester holds add_valid/add_pts until add_ready.

Reset
- REQ-021 rst_n low: immediately state=IDLE, score_1..4=0, overflow=0, busy=0, carry=0, idx=0.
- REQ-022 add_ready low while rst_n low; it asserts on the first edge after release where clear is low.
- REQ-023 Reset mid-ADD discards the partial addition; no partial digit update survives.

Configuration
- REQ-024 Macro SCORE_SATURATE_EN defined: on thousands overflow, all four digits are forced to 9 (score 9999) and further adds leave 9999 unchanged, overflow set.
- REQ-025 SCORE_SATURATE_EN undefined: thousands overflow wraps (digit keeps sum-10, lower digits keep computed values), e.g. 9999+1 -> 0000, overflow set.

Verification
- REQ-026 Reset, then add 7, then add 5 -> score 0012, busy one cycle then two cycles, overflow 0.
- REQ-027 From 0999 add 1 -> ones, tens, hundreds zeroed, thousands 1 at edge N+4; add_ready low for edges N..N+3.
- REQ-028 From 9998 add 3: with SCORE_SATURATE_EN -> 9999, overflow 1; without -> 0001, overflow 1.
- REQ-029 add_pts=15 with PTS_MAX=9 from 0000 -> 0009; add_pts=0 -> unchanged after one busy cycle.
- REQ-030 clear asserted during ADD of 0999+1 at edge N+2 -> 0000, overflow 0, IDLE next edge; clear with add_valid in IDLE -> add not accepted.
- REQ-031 rst_n pulsed low mid-ADD, asynchronous to clk -> outputs 0 immediately, no further digit change until a new request.
